// File: rtl/sp_ram_ctrl_if.sv
// Request/response bundle for sp_ram_ctrl: master issues accesses, slave returns
// registered read data with a one-cycle valid strobe and a sticky init flag.
interface sp_ram_ctrl_if #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 5
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;
  logic [DATA_WIDTH-1:0] out;
  logic                  out_valid;
  logic                  init_done;

  modport master (
    output req, we, addr, data,
    input  ready, out, out_valid, init_done
  );

  modport slave (
    input  req, we, addr, data,
    output ready, out, out_valid, init_done
  );
endinterface

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM controller: 1-cycle registered read, 1 access/clk, optional post-reset zero fill.
// ready is low during reset and the clear sweep; requests seen while not ready are dropped.
module sp_ram_ctrl #(
  parameter int DATA_WIDTH     = 5,
  parameter int ADDR_WIDTH     = 5,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  sp_ram_ctrl_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  ready;
  logic                  accept;
  logic                  clear_last;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdat;

  assign clear_last = (cnt_q == CNT_W'(DEPTH - 1));
  assign accept     = bus.req & ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && clear_last) begin
      state_d = ST_IDLE;
    end
  end

  // Gating the write strobe with reset_n keeps a held reset from scribbling on word 0.
  always_comb begin
    ready     = (state_q == ST_IDLE) && init_done_q;
    mem_we    = reset_n & accept & bus.we;
    mem_waddr = bus.addr;
    mem_wdat  = bus.data;
    if (state_q == ST_CLEAR) begin
      mem_we    = reset_n;
      mem_waddr = cnt_q[ADDR_WIDTH-1:0];
      mem_wdat  = '0;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    out_d       = out_q;
    out_valid_d = accept;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear_last) begin
        init_done_d = 1'b1;
      end
    end else begin
      init_done_d = 1'b1;
    end
    // Array read sees the pre-edge contents, which gives read-first for free.
    if (accept) begin
      out_d = (bus.we && RDW_MODE != 0) ? bus.data : mem_q[bus.addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdat;
    end
  end

  assign bus.ready     = ready;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.init_done = init_done_q;
endmodule
